// File: rtl/pe_sched_pkg.sv
// Shared widths, FIFO depth and FSM states for the convolution PE sequencer.
package pe_sched_pkg;

  localparam int PIX_W      = 8;
  localparam int W_W        = 8;
  localparam int PO_W       = 11;
  localparam int M_W        = 16;
  localparam int FIFO_DEPTH = 2;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } state_t;

  function automatic logic [M_W-1:0] sext_po(input logic [PO_W-1:0] x);
    return {{(M_W-PO_W){x[PO_W-1]}}, x};
  endfunction

endpackage

// File: rtl/sched_ofifo.sv
// Two-entry synchronous result FIFO; a push while full is accepted only
// when a pop frees the head slot in the same cycle.
module sched_ofifo
  import pe_sched_pkg::*;
#(
  parameter int WIDTH = M_W + 1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic [1:0]       count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [FIFO_DEPTH];
  logic             wr_ptr;
  logic             rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == 2'(FIFO_DEPTH));
  assign empty   = (count == 2'd0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop) rd_ptr <= ~rd_ptr;
      count <= count + 2'(do_push) - 2'(do_pop);
    end
  end

endmodule

// File: rtl/pe_conv_sched.sv
// Sequencer for a 3-tap convolution PE: sliding pixel window per row,
// credit-based issue into a 2-deep result FIFO, and frame start/done control.
module pe_conv_sched
  import pe_sched_pkg::*;
#(
  parameter int IMG_W  = 64,
  parameter int ROW_CW = 16
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  input  logic [ROW_CW-1:0] cfg_rows,
  input  logic [W_W-1:0]    cfg_w1,
  input  logic [W_W-1:0]    cfg_w2,
  input  logic [W_W-1:0]    cfg_w3,
  output logic              busy,
  output logic              done,
  output logic              err,
  input  logic [PIX_W-1:0]  s_tdata,
  input  logic              s_tvalid,
  output logic              s_tready,
  input  logic              s_tlast,
  output logic [W_W-1:0]    pe_w1,
  output logic [W_W-1:0]    pe_w2,
  output logic [W_W-1:0]    pe_w3,
  output logic [3*PIX_W-1:0] pe_p,
  output logic              pe_p_valid,
  input  logic [PO_W-1:0]   pe_o,
  input  logic              pe_o_valid,
  output logic [M_W-1:0]    m_tdata,
  output logic              m_tvalid,
  input  logic              m_tready,
  output logic              m_tlast
);

  localparam int              COL_W    = $clog2(IMG_W);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);

  state_t             state, state_next;
  logic [ROW_CW-1:0]  rows_q;
  logic [ROW_CW-1:0]  row;
  logic [COL_W-1:0]   col;
  logic [W_W-1:0]     w1_q, w2_q, w3_q;
  logic [PIX_W-1:0]   px_m2, px_m1;
  logic               inflight;
  logic               inflight_last;
  logic               err_q;
  logic               zero_done_q;

  logic               accept;
  logic               issue;
  logic               last_pix;
  logic               m_pop;
  logic [2:0]         credit_used;

  logic [M_W:0]       fifo_rdata;
  logic [1:0]         fifo_cnt;
  logic               fifo_full;
  logic               fifo_empty;

  assign accept   = s_tvalid && s_tready;
  assign last_pix = (col == COL_LAST) && (row == rows_q - ROW_CW'(1));
  assign issue    = accept && (col >= COL_W'(2));
  assign m_pop    = m_tvalid && m_tready;

  // Every issued triplet must find a FIFO slot one cycle later, since the PE cannot stall.
  assign credit_used = {1'b0, fifo_cnt} + {2'b0, inflight} - {2'b0, m_pop};
  assign s_tready    = (state == RUN) && (credit_used < 3'(FIFO_DEPTH))
                       && !(fifo_full && !m_pop);

  assign busy       = (state != IDLE);
  assign err        = err_q;
  assign pe_w1      = w1_q;
  assign pe_w2      = w2_q;
  assign pe_w3      = w3_q;
  assign pe_p       = {px_m2, px_m1, s_tdata};
  assign pe_p_valid = issue;

  assign m_tvalid = !fifo_empty;
  assign m_tdata  = fifo_rdata[M_W-1:0];
  assign m_tlast  = fifo_rdata[M_W] && !fifo_empty;

  always_ff @(posedge clk) begin
    if (!rstn) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    done       = zero_done_q;
    case (state)
      IDLE:  if (start && (cfg_rows != '0)) state_next = RUN;
      RUN:   if (accept && last_pix) state_next = DRAIN;
      DRAIN: if (!inflight && fifo_empty) begin
        state_next = IDLE;
        done       = 1'b1;
      end
      default: state_next = IDLE;
    endcase
  end

  // The window is zeroed at each row end so no triplet ever mixes two rows.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      rows_q        <= '0;
      row           <= '0;
      col           <= '0;
      w1_q          <= '0;
      w2_q          <= '0;
      w3_q          <= '0;
      px_m2         <= '0;
      px_m1         <= '0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
      err_q         <= 1'b0;
      zero_done_q   <= 1'b0;
    end else begin
      zero_done_q   <= (state == IDLE) && start && (cfg_rows == '0);
      inflight      <= issue;
      inflight_last <= issue && last_pix;
      if ((state == IDLE) && start) begin
        err_q  <= 1'b0;
        rows_q <= cfg_rows;
        w1_q   <= cfg_w1;
        w2_q   <= cfg_w2;
        w3_q   <= cfg_w3;
        col    <= '0;
        row    <= '0;
        px_m2  <= '0;
        px_m1  <= '0;
      end else if (accept) begin
        if (s_tlast != last_pix) err_q <= 1'b1;
        if (col == COL_LAST) begin
          col   <= '0;
          row   <= row + ROW_CW'(1);
          px_m2 <= '0;
          px_m1 <= '0;
        end else begin
          col   <= col + COL_W'(1);
          px_m2 <= px_m1;
          px_m1 <= s_tdata;
        end
      end
    end
  end

  sched_ofifo #(.WIDTH(M_W + 1)) u_ofifo (
    .clk   (clk),
    .rstn  (rstn),
    .push  (pe_o_valid),
    .wdata ({inflight_last, sext_po(pe_o)}),
    .pop   (m_pop),
    .rdata (fifo_rdata),
    .count (fifo_cnt),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

endmodule

// File: tb/tb_pe_conv_sched.sv
// Scoreboard bench for pe_conv_sched with a 1-cycle stub PE computing
// (w1*p_old + w2*p_mid + w3*p_new) >>> 6.
module tb_pe_conv_sched;

  localparam int IMG_W  = 4;
  localparam int ROW_CW = 16;

  logic              clk = 1'b0;
  logic              rstn;
  logic              start;
  logic [ROW_CW-1:0] cfg_rows;
  logic [7:0]        cfg_w1, cfg_w2, cfg_w3;
  logic              busy, done, err;
  logic [7:0]        s_tdata;
  logic              s_tvalid, s_tready, s_tlast;
  logic [7:0]        pe_w1, pe_w2, pe_w3;
  logic [23:0]       pe_p;
  logic              pe_p_valid;
  logic [10:0]       pe_o;
  logic              pe_o_valid;
  logic [15:0]       m_tdata;
  logic              m_tvalid, m_tready, m_tlast;

  int          n_vec    = 0;
  int          n_err    = 0;
  int          done_cnt = 0;
  int          pe_sum;
  logic [16:0] exp_q[$];
  logic [7:0]  pix[$];

  always #5 clk = ~clk;

  pe_conv_sched #(.IMG_W(IMG_W), .ROW_CW(ROW_CW)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .start      (start),
    .cfg_rows   (cfg_rows),
    .cfg_w1     (cfg_w1),
    .cfg_w2     (cfg_w2),
    .cfg_w3     (cfg_w3),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .s_tdata    (s_tdata),
    .s_tvalid   (s_tvalid),
    .s_tready   (s_tready),
    .s_tlast    (s_tlast),
    .pe_w1      (pe_w1),
    .pe_w2      (pe_w2),
    .pe_w3      (pe_w3),
    .pe_p       (pe_p),
    .pe_p_valid (pe_p_valid),
    .pe_o       (pe_o),
    .pe_o_valid (pe_o_valid),
    .m_tdata    (m_tdata),
    .m_tvalid   (m_tvalid),
    .m_tready   (m_tready),
    .m_tlast    (m_tlast)
  );

  // Stub PE: pixels unsigned, weights signed, fixed 1-cycle latency.
  always_comb pe_sum = int'($signed(pe_w1)) * int'(pe_p[23:16])
                     + int'($signed(pe_w2)) * int'(pe_p[15:8])
                     + int'($signed(pe_w3)) * int'(pe_p[7:0]);

  always @(posedge clk) begin
    if (!rstn) begin
      pe_o_valid <= 1'b0;
      pe_o       <= '0;
    end else begin
      pe_o_valid <= pe_p_valid;
      pe_o       <= 11'(pe_sum >>> 6);
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_err++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
    end
  endtask

  task automatic send_pixel(input logic [7:0] d, input logic last);
    int t   = 0;
    bit got = 0;
    s_tdata  = d;
    s_tvalid = 1'b1;
    s_tlast  = last;
    while (!got && t < 500) begin
      @(negedge clk);
      if (s_tready) got = 1;
      else t++;
    end
    if (!got) checkOutput("s_tready_timeout", 0, 1);
    @(posedge clk);
    #1;
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    s_tdata  = '0;
  endtask

  task automatic applyStimulus(input logic [15:0] rows, input logic [7:0] w1, input logic [7:0] w2,
                               input logic [7:0] w3, input int tlast_at, input string tag);
    int base = done_cnt;
    int t    = 0;
    cfg_rows = rows;
    cfg_w1   = w1;
    cfg_w2   = w2;
    cfg_w3   = w3;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    foreach (pix[i]) send_pixel(pix[i], i == tlast_at);
    while (busy && t < 500) begin
      @(negedge clk);
      t++;
    end
    if (busy) checkOutput({tag, "_drain_timeout"}, 0, 1);
    @(negedge clk);
    checkOutput({tag, "_done_pulses"}, done_cnt - base, 1);
    checkOutput({tag, "_results_left"}, exp_q.size(), 0);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int base;
    logic [16:0] e;
    rstn     = 1'b0;
    start    = 1'b0;
    cfg_rows = '0;
    cfg_w1   = '0;
    cfg_w2   = '0;
    cfg_w3   = '0;
    s_tdata  = '0;
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    m_tready = 1'b1;

    fork
      forever begin
        @(negedge clk);
        if (rstn && m_tvalid && m_tready) begin
          if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("[TB] FAIL unexpected_result: got 0x%0h last=%0b, expected no result", m_tdata, m_tlast);
          end else begin
            e = exp_q.pop_front();
            checkOutput("m_tdata", m_tdata, e[15:0]);
            checkOutput("m_tlast", m_tlast, e[16]);
          end
        end
      end
      forever begin
        @(negedge clk);
        if (done) done_cnt++;
      end
    join_none

    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_err", err, 0);
    checkOutput("rst_s_tready", s_tready, 0);
    checkOutput("rst_m_tvalid", m_tvalid, 0);
    checkOutput("rst_m_tdata", m_tdata, 0);
    checkOutput("rst_pe_p_valid", pe_p_valid, 0);
    checkOutput("rst_pe_w", {pe_w1, pe_w2, pe_w3}, 0);
    @(posedge clk);
    #1 rstn = 1'b1;
    @(posedge clk);
    #1;

    $display("[TB] test 1: basic 1x4 frame");
    pix = '{8'd0, 8'd64, 8'd128, 8'd192};
    exp_q.push_back({1'b0, 16'h0003});
    exp_q.push_back({1'b1, 16'h0006});
    applyStimulus(1, 8'd1, 8'd1, 8'd1, 3, "t1");
    checkOutput("t1_err", err, 0);

    $display("[TB] test 2: negative weights, sign extension");
    pix = '{8'd255, 8'd255, 8'd255, 8'd255};
    exp_q.push_back({1'b0, 16'hFFF4});
    exp_q.push_back({1'b1, 16'hFFF4});
    applyStimulus(1, 8'hFF, 8'hFF, 8'hFF, 3, "t2");
    checkOutput("t2_err", err, 0);

    $display("[TB] test 3: 3 rows under output backpressure");
    pix = '{8'd0, 8'd64, 8'd128, 8'd192, 8'd64, 8'd64, 8'd64, 8'd64, 8'd0, 8'd0, 8'd0, 8'd0};
    exp_q.push_back({1'b0, 16'h0003});
    exp_q.push_back({1'b0, 16'h0006});
    exp_q.push_back({1'b0, 16'h0003});
    exp_q.push_back({1'b0, 16'h0003});
    exp_q.push_back({1'b0, 16'h0000});
    exp_q.push_back({1'b1, 16'h0000});
    m_tready = 1'b0;
    fork
      applyStimulus(3, 8'd1, 8'd1, 8'd1, 11, "t3");
      begin
        repeat (20) @(posedge clk);
        @(negedge clk);
        checkOutput("t3_stalled_s_tready", s_tready, 0);
        checkOutput("t3_held_m_tvalid", m_tvalid, 1);
        checkOutput("t3_held_m_tdata", m_tdata, 16'h0003);
        @(posedge clk);
        #1 m_tready = 1'b1;
      end
    join

    $display("[TB] test 4: row boundary");
    pix = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd100, 8'd101, 8'd102, 8'd103};
    exp_q.push_back({1'b0, 16'd1});
    exp_q.push_back({1'b0, 16'd2});
    exp_q.push_back({1'b0, 16'd100});
    exp_q.push_back({1'b1, 16'd101});
    applyStimulus(2, 8'd64, 8'd0, 8'd0, 7, "t4");
    checkOutput("t4_err", err, 0);

    $display("[TB] test 5: early tlast sets sticky err");
    pix = '{8'd64, 8'd64, 8'd64, 8'd64, 8'd64, 8'd64, 8'd64, 8'd64};
    exp_q.push_back({1'b0, 16'h0003});
    exp_q.push_back({1'b0, 16'h0003});
    exp_q.push_back({1'b0, 16'h0003});
    exp_q.push_back({1'b1, 16'h0003});
    applyStimulus(2, 8'd1, 8'd1, 8'd1, 2, "t5");
    checkOutput("t5_err", err, 1);
    repeat (3) @(negedge clk);
    checkOutput("t5_err_sticky", err, 1);

    $display("[TB] test 6: mid-frame reset, restart, zero-row start");
    @(posedge clk);
    #1;
    cfg_rows = 16'd2;
    cfg_w1   = 8'd1;
    cfg_w2   = 8'd1;
    cfg_w3   = 8'd1;
    start    = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    checkOutput("t6_err_cleared", err, 0);
    checkOutput("t6_busy", busy, 1);
    send_pixel(8'd10, 1'b0);
    send_pixel(8'd20, 1'b0);
    base = done_cnt;
    rstn = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checkOutput("t6_rst_busy", busy, 0);
    checkOutput("t6_rst_s_tready", s_tready, 0);
    checkOutput("t6_rst_m_tvalid", m_tvalid, 0);
    checkOutput("t6_rst_pe_w1", pe_w1, 0);
    checkOutput("t6_rst_pe_p", pe_p, 0);
    @(posedge clk);
    #1 rstn = 1'b1;
    repeat (5) @(negedge clk);
    checkOutput("t6_no_done", done_cnt - base, 0);
    @(posedge clk);
    #1;

    pix = '{8'd0, 8'd64, 8'd128, 8'd192};
    exp_q.push_back({1'b0, 16'h0003});
    exp_q.push_back({1'b1, 16'h0006});
    applyStimulus(1, 8'd1, 8'd1, 8'd1, 3, "t6b");
    checkOutput("t6b_err", err, 0);

    @(posedge clk);
    #1;
    base     = done_cnt;
    cfg_rows = '0;
    start    = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    checkOutput("zero_done", done, 1);
    checkOutput("zero_busy", busy, 0);
    repeat (3) @(negedge clk);
    checkOutput("zero_done_once", done_cnt - base, 1);
    checkOutput("zero_m_tvalid", m_tvalid, 0);
    checkOutput("zero_s_tready", s_tready, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pe_conv_sched.md
Name: pe_conv_sched

Overview:
Sequencer for one 3-tap signed-weight convolution PE. The PE takes a 24-bit pixel triplet with p_valid, returns o (11-bit signed) with o_valid exactly 1 cycle later, and has no stall input.
- Input side: AXI-Stream-style 8-bit pixel stream from the DMA.
- Per row: builds a 3-pixel sliding window and issues valid-mode convolutions to the PE.
- Output side: collects results and emits a 16-bit sign-extended result stream with backpressure.
- Owns the weight registers and frame sequencing (start/done).

Parameters:
- IMG_W, 64, pixels per row; legal range 3..4096.
- ROW_CW, 16, width of the row-count config and row counter.

Ports:
- clk  in  1  clock
- rstn  in  1  reset, synchronous, active-low
- start  in  1  1-cycle pulse; honoured only in IDLE
- cfg_rows  in  ROW_CW  rows in the frame; sampled on start
- cfg_w1, cfg_w2, cfg_w3  in  8 each  signed weights; sampled on start
- busy  out  1  high when state is not IDLE
- done  out  1  1-cycle pulse at frame completion
- err  out  1  sticky tlast-mismatch flag; cleared by start
- s_tdata  in  8  pixel
- s_tvalid  in  1  pixel valid
- s_tready  out  1  pixel ready
- s_tlast  in  1  last pixel of frame
- pe_w1, pe_w2, pe_w3  out  8 each  registered weights to the PE
- pe_p  out  24  triplet to the PE: [23:16] oldest, [7:0] newest
- pe_p_valid  out  1  issue strobe
- pe_o  in  11  signed PE result
- pe_o_valid  in  1  PE result valid
- m_tdata  out  16  sign-extended pe_o
- m_tvalid  out  1  result valid
- m_tready  in  1  result ready
- m_tlast  out  1  last result of frame

Behaviour:
- Reset values: all outputs 0; state IDLE; FIFO empty; counters, window and err cleared. Reset mid-frame abandons the frame and emits no done.
- States: IDLE, RUN, DRAIN.
  - IDLE -> RUN on start when cfg_rows != 0. Latch weights and row count; clear col, row and err.
  - start with cfg_rows == 0: done pulses the next cycle; state stays IDLE.
  - RUN -> DRAIN on the accept of the pixel at col == IMG_W-1 and row == rows-1.
  - DRAIN -> IDLE when no PE result is in flight and the FIFO is empty. done pulses in the same cycle as the transition.
  - start outside IDLE is ignored.
- Accept: a pixel is accepted when s_tvalid && s_tready.
- Counters: col counts 0..IMG_W-1 and wraps to 0 on each row end, incrementing row. The window registers (px_m2, px_m1) shift on every accept.
- Window reset: the window is logically cleared at each row start. No output is issued for col 0 or col 1, so outputs never straddle rows.
- Issue: pe_p_valid = accept && col >= 2, combinational. pe_p = {px_m2, px_m1, s_tdata}. Each row yields IMG_W-2 results.
- Credit and flow control:
  - Output FIFO depth is 2. inflight is the registered pe_p_valid.
  - s_tready = (state == RUN) && (fifo_cnt + inflight + (m_pop ? -1 : 0) < 2).
  - This guarantees a FIFO slot for every pe_o_valid, because the PE cannot stall.
- Output:
  - FIFO write on pe_o_valid; a simultaneous push and pop keeps the count unchanged.
  - m_tdata = sign-extend(pe_o).
  - m_tlast marks the result from the last window of the last row. The tag travels alongside the issue and is stored per FIFO entry.
- Latency: accept in cycle N gives pe_o_valid in N+1 and m_tvalid in N+2 when the FIFO was empty.
- err is set when either condition holds:
  - s_tlast is seen on a pixel other than the final one;
  - s_tlast is absent on the final pixel.
  Data flow continues regardless; frame length is always taken from cfg_rows x IMG_W.
- Weights are constant from start until done. The cfg_w* inputs are not used mid-frame.

Decomposition:
- Package pe_sched_pkg holds PIX_W=8, W_W=8, PO_W=11, M_W=16, the FIFO_DEPTH=2 constant, and the state enum {IDLE, RUN, DRAIN}.
- One sub-module, sched_ofifo: a 2-entry synchronous FIFO, 17 bits wide (data + last), with count, full and empty outputs.

Test Plan:
1. IMG_W=4, rows=1, w=(1,1,1), pixels 0,64,128,192 -> two results, m_tdata 0x0003 then 0x0006 (tlast). done pulses once and err=0.
2. w=(-1,-1,-1), pixels 255,255,255,255 with a stub PE -> results 0xFFF4, 0xFFF4 (-765>>>6=-12); sign extension checked.
3. IMG_W=4, rows=3, m_tready held low for 20 cycles -> s_tready drops once fifo_cnt+inflight reaches 2. No result lost or duplicated; 6 results total and tlast only on the 6th.
4. Row-boundary check: rows=2, row0=1..4, row1=100..103, w=(64,0,0) -> results 1,2,100,101. No window mixes rows.
5. s_tlast asserted on the 3rd pixel of a 2x4 frame -> err=1 sticky; 4 results still emitted; done still pulses. A subsequent start clears err.
6. rstn low for one cycle mid-RUN -> all outputs 0, state IDLE, and no done pulse. A new start then completes a correct frame. start with cfg_rows=0 -> done pulse with no stream activity.
